// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial pattern transmitter.
// Latches a PATTERN_W-bit pattern and a repeat count on a ready/start
// handshake, then shifts the pattern out MSB-first, one bit per clock, for the
// requested number of repeats. Repeats are separated by GAP_CYCLES idle
// cycles. Completion is flagged by a one-cycle done pulse.
// Optional feature: define SEQ_GEN_PARITY_EN to append one even-parity bit
// (XOR of the latched pattern) after every repeat.
// All outputs are registered; rst is synchronous and active-high.
module seq_pattern_gen #(
  parameter int PATTERN_W  = 4,
  parameter int CNT_W      = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [PATTERN_W-1:0] pattern,
  input  logic [CNT_W-1:0]     repeat_cnt,
  input  logic                 abort,
  output logic                 ready,
  output logic                 busy,
  output logic                 out,
  output logic                 out_valid,
  output logic                 done
);

  localparam int IDX_W    = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;
  localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
`ifdef SEQ_GEN_PARITY_EN
    ,S_PARITY
`endif
  } state_t;

  state_t               state_reg, state_next;
  logic [PATTERN_W-1:0] pat_reg, pat_next;      // latched pattern, used for reloads and parity
  logic [PATTERN_W-1:0] sh_reg, sh_next;        // shift register, MSB is the bit on the line
  logic [IDX_W-1:0]     bit_idx_reg, bit_idx_next;
  logic [CNT_W-1:0]     rem_reg, rem_next;      // repeats still owed, including the current one
  logic [GAP_W-1:0]     gap_cnt_reg, gap_cnt_next;
  logic                 out_reg, out_next;
  logic                 out_valid_reg, out_valid_next;
  logic                 done_reg, done_next;
  logic                 ready_reg, ready_next;
  logic                 busy_reg, busy_next;
  logic                 repeat_end;             // last bit of a repeat has just been shown
  logic                 reload;                 // start the next repeat with its MSB

  // State and output registers; rst returns everything to an idle, ready state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      pat_reg       <= '0;
      sh_reg        <= '0;
      bit_idx_reg   <= '0;
      rem_reg       <= '0;
      gap_cnt_reg   <= '0;
      out_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
      ready_reg     <= 1'b1;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pat_reg       <= pat_next;
      sh_reg        <= sh_next;
      bit_idx_reg   <= bit_idx_next;
      rem_reg       <= rem_next;
      gap_cnt_reg   <= gap_cnt_next;
      out_reg       <= out_next;
      out_valid_reg <= out_valid_next;
      done_reg      <= done_next;
      ready_reg     <= ready_next;
      busy_reg      <= busy_next;
    end
  end

  // Next-state and next-output logic; outputs default to an idle line each cycle.
  always_comb begin
    state_next     = state_reg;
    pat_next       = pat_reg;
    sh_next        = sh_reg;
    bit_idx_next   = bit_idx_reg;
    rem_next       = rem_reg;
    gap_cnt_next   = gap_cnt_reg;
    out_next       = 1'b0;
    out_valid_next = 1'b0;
    done_next      = 1'b0;
    repeat_end     = 1'b0;
    reload         = 1'b0;

    case (state_reg)
      S_IDLE: begin
        // abort in IDLE drops a simultaneous start
        if (start && !abort) begin
          pat_next = pattern;
          rem_next = repeat_cnt;
          if (repeat_cnt == '0) begin
            done_next = 1'b1;
          end else begin
            sh_next        = pattern;
            bit_idx_next   = '0;
            out_next       = pattern[PATTERN_W-1];
            out_valid_next = 1'b1;
            state_next     = S_SHIFT;
          end
        end
      end

      S_SHIFT: begin
        if (bit_idx_reg == IDX_W'(PATTERN_W - 1)) begin
`ifdef SEQ_GEN_PARITY_EN
          out_next       = ^pat_reg;
          out_valid_next = 1'b1;
          state_next     = S_PARITY;
`else
          repeat_end     = 1'b1;
`endif
        end else begin
          sh_next        = sh_reg << 1;
          bit_idx_next   = bit_idx_reg + IDX_W'(1);
          out_next       = sh_reg[PATTERN_W-2];
          out_valid_next = 1'b1;
        end
      end

      S_GAP: begin
        if (gap_cnt_reg == GAP_W'(GAP_LAST)) begin
          reload = 1'b1;
        end else begin
          gap_cnt_next = gap_cnt_reg + GAP_W'(1);
        end
      end

`ifdef SEQ_GEN_PARITY_EN
      S_PARITY: begin
        repeat_end = 1'b1;
      end
`endif

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // End of one repeat: either another repeat follows (with or without a gap)
    // or the transfer is complete.
    if (repeat_end) begin
      if (rem_reg > CNT_W'(1)) begin
        rem_next = rem_reg - CNT_W'(1);
        if (GAP_CYCLES > 0) begin
          gap_cnt_next = '0;
          state_next   = S_GAP;
        end else begin
          reload = 1'b1;
        end
      end else begin
        rem_next   = '0;
        done_next  = 1'b1;
        state_next = S_IDLE;
      end
    end

    if (reload) begin
      sh_next        = pat_reg;
      bit_idx_next   = '0;
      out_next       = pat_reg[PATTERN_W-1];
      out_valid_next = 1'b1;
      state_next     = S_SHIFT;
    end

    // A busy transfer is cancelled outright: idle line, no done pulse.
    if (abort && (state_reg != S_IDLE)) begin
      state_next     = S_IDLE;
      rem_next       = '0;
      out_next       = 1'b0;
      out_valid_next = 1'b0;
      done_next      = 1'b0;
    end

    ready_next = (state_next == S_IDLE);
    busy_next  = (state_next != S_IDLE);
  end

  assign ready     = ready_reg;
  assign busy      = busy_reg;
  assign out       = out_reg;
  assign out_valid = out_valid_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: directed bench for seq_pattern_gen (PATTERN_W=4,
// CNT_W=4, GAP_CYCLES=2). A queue-based model expands every accepted request
// into the full per-cycle output stream; each cycle the DUT outputs are
// compared against it, and literal expectations pin the captured streams.
module tb_seq_pattern_gen;

  localparam int PW  = 4;
  localparam int CW  = 4;
  localparam int GAP = 2;
`ifdef SEQ_GEN_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [PW-1:0] pattern;
  logic [CW-1:0] repeat_cnt;
  logic          abort;
  logic          ready, busy, out, out_valid, done;

  int vectors     = 0;
  int miscompares = 0;

  seq_pattern_gen #(
    .PATTERN_W (PW),
    .CNT_W     (CW),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pattern   (pattern),
    .repeat_cnt(repeat_cnt),
    .abort     (abort),
    .ready     (ready),
    .busy      (busy),
    .out       (out),
    .out_valid (out_valid),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Expected outputs for one cycle, packed as out/out_valid/done/busy/ready.
  typedef struct packed {
    logic o;
    logic v;
    logic d;
    logic b;
    logic r;
  } exp_t;

  localparam exp_t IDLE_E = '{o: 1'b0, v: 1'b0, d: 1'b0, b: 1'b0, r: 1'b1};

  exp_t q[$];
  exp_t cur  = IDLE_E;
  bit   live = 1'b0;

  // Expand an accepted request into its whole output stream.
  task automatic build(input logic [PW-1:0] p, input logic [CW-1:0] c);
    exp_t e;
    for (int r = 0; r < int'(c); r++) begin
      for (int i = PW - 1; i >= 0; i--) begin
        e = '{o: p[i], v: 1'b1, d: 1'b0, b: 1'b1, r: 1'b0};
        q.push_back(e);
      end
      if (PB == 1) begin
        e = '{o: ^p, v: 1'b1, d: 1'b0, b: 1'b1, r: 1'b0};
        q.push_back(e);
      end
      if (r < int'(c) - 1) begin
        for (int g = 0; g < GAP; g++) begin
          e = '{o: 1'b0, v: 1'b0, d: 1'b0, b: 1'b1, r: 1'b0};
          q.push_back(e);
        end
      end
    end
    e = '{o: 1'b0, v: 1'b0, d: 1'b1, b: 1'b0, r: 1'b1};
    q.push_back(e);
  endtask

  // Model: advance one cycle per rising edge using the same inputs the DUT sees.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      cur  = IDLE_E;
      live = 1'b1;
    end else if (live) begin
      if (cur.b && abort) begin
        q.delete();
        cur = IDLE_E;
      end else begin
        if (cur.r && start && !abort) build(pattern, repeat_cnt);
        if (q.size() > 0) cur = q.pop_front();
        else              cur = IDLE_E;
      end
    end
  end

  // Advance to the next falling edge and compare every DUT output to the model.
  task automatic tick();
    @(negedge clk);
    if (live) begin
      vectors++;
      if ({out, out_valid, done, busy, ready} !== cur) begin
        miscompares++;
        $display("FAIL cyc t=%0t o/v/d/b/r got %b%b%b%b%b required %b",
                 $time, out, out_valid, done, busy, ready, cur);
      end
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got %0d required %0d", name, got, exp);
    end
  endtask

  // One request: drive it at a falling edge, capture the valid bits until done
  // (or until a bounded number of cycles), and check the literal expectations.
  task automatic txn(input string name, input logic [PW-1:0] p, input logic [CW-1:0] c,
                     input int exp_bits, input int exp_n, input int exp_done,
                     input int poke_at, input int abort_at);
    logic [31:0] bits = '0;
    int n      = 0;
    int got_at = -1;
    int limit  = (exp_done >= 0) ? exp_done + 10 : abort_at + 8;
    start      = 1'b1;
    pattern    = p;
    repeat_cnt = c;
    tick();
    start = 1'b0;
    for (int i = 0; ; i++) begin
      if (out_valid) begin
        bits = {bits[30:0], out};
        n++;
      end
      if (done) begin
        got_at = i;
        break;
      end
      start = 1'b0;
      abort = 1'b0;
      if (i == poke_at) begin
        start      = 1'b1;
        pattern    = ~p;
        repeat_cnt = '1;
      end
      if (i == abort_at) abort = 1'b1;
      if (i >= limit) break;
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    $display("txn %s pattern=%b cnt=%0d bits=%0d stream=%b done_at=%0d",
             name, p, c, n, bits[15:0], got_at);
    chk({name, "_bits"}, int'(bits), exp_bits);
    chk({name, "_nbits"}, n, exp_n);
    chk({name, "_done_at"}, got_at, exp_done);
  endtask

  int done_seen;

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    pattern    = '0;
    repeat_cnt = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_ready", int'(ready), 1);
    chk("reset_busy", int'(busy), 0);

    // Single repeat: 1,1,0,1 (+ parity) then done.
    if (PB == 1) txn("basic", 4'b1101, 4'd1, 'b11011, 5, 5, -1, -1);
    else         txn("basic", 4'b1101, 4'd1, 'b1101, 4, 4, -1, -1);
    chk("basic_done_ready", int'(ready), 1);
    tick();
    chk("basic_done_pulse", int'(done), 0);

    // Three repeats with two-cycle gaps.
    if (PB == 1) txn("gap", 4'b1101, 4'd3, 'b110111101111011, 15, 19, -1, -1);
    else         txn("gap", 4'b1101, 4'd3, 'b110111011101, 12, 16, -1, -1);
    tick();

    // Zero count, then a start in the done cycle, then another back-to-back.
    txn("zero", 4'b1010, 4'd0, 0, 0, 0, -1, -1);
    if (PB == 1) txn("b2b", 4'b0110, 4'd1, 'b01100, 5, 5, -1, -1);
    else         txn("b2b", 4'b0110, 4'd1, 'b0110, 4, 4, -1, -1);
    // start and changed pattern/count mid-transfer must be ignored
    if (PB == 1) txn("poke", 4'b1101, 4'd2, 'b1101111011, 10, 12, 2, -1);
    else         txn("poke", 4'b1101, 4'd2, 'b11011101, 8, 10, 2, -1);
    tick();

    // Abort while bit 2 of repeat 2 is on the line.
    if (PB == 1) txn("abort", 4'b1101, 4'd3, 'b11011110, 8, -1, -1, 9);
    else         txn("abort", 4'b1101, 4'd3, 'b1101110, 7, -1, -1, 8);
    chk("abort_valid", int'(out_valid), 0);
    chk("abort_ready", int'(ready), 1);

    // Reset held three cycles mid-transfer, then no done afterwards.
    start      = 1'b1;
    pattern    = 4'b1011;
    repeat_cnt = 4'd3;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(ready), 1);
    chk("rst_done", int'(done), 0);
    done_seen = 0;
    repeat (20) begin
      tick();
      if (done) done_seen++;
    end
    chk("rst_no_done", done_seen, 0);
    $display("txn reset mid-transfer done_pulses=%0d", done_seen);

    // start together with abort in IDLE: nothing is sent.
    start      = 1'b1;
    abort      = 1'b1;
    pattern    = 4'b1111;
    repeat_cnt = 4'd1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    done_seen = 0;
    repeat (6) begin
      if (out_valid || busy || done) done_seen++;
      tick();
    end
    chk("idle_abort_activity", done_seen, 0);
    $display("txn start+abort in idle activity_cycles=%0d", done_seen);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
- Serial pattern transmitter: latches a PATTERN_W-bit pattern and a repeat count, then shifts the pattern out MSB-first, one bit per clock, for the requested number of repeats.
- Stimulus source for the serial pattern detectors in the design and their loopback tests. For example, a pattern of 4'b1101 produces the 1-1-0-1 stream that the detectors consume.
- Start handshake is ready/start. Completion is a one-cycle done pulse.

Parameters:
- PATTERN_W, 4, pattern length in bits (≥2).
- CNT_W, 4, width of the repeat count.
- GAP_CYCLES, 0, idle cycles inserted between consecutive repeats (0 means back-to-back).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; accepted on an edge where start=1 and ready=1.
- pattern  input  PATTERN_W  pattern to send; sampled at accept.
- repeat_cnt  input  CNT_W  number of repeats; sampled at accept.
- abort  input  1  synchronous cancel of the current transfer.
- ready  output  1  high in IDLE, able to accept start.
- busy  output  1  high while a transfer is in progress (SHIFT, GAP or PARITY).
- out  output  1  serial data bit.
- out_valid  output  1  high when out carries a pattern (or parity) bit.
- done  output  1  one-cycle pulse after the final bit.

Behaviour:
- All outputs are registered.
- On rst=1 at an edge: state=IDLE, ready=1, busy=0, out=0, out_valid=0, done=0, and all counters cleared. rst overrides every other input.

States:
- IDLE
  - On accept: latch the pattern into a shift register and the count into rem.
  - If repeat_cnt==0: no bits are sent; done=1 on the next cycle; stay in IDLE.
  - Otherwise, at the accepting edge: out=pattern[PATTERN_W-1], out_valid=1, busy=1, ready=0, bit_idx=0; go to SHIFT. Latency from accept edge to first valid bit is 0 cycles after that edge.
- SHIFT
  - Each edge presents the next bit, MSB→LSB.
  - After bit PATTERN_W-1 (LSB) has been presented for one cycle, the next edge leaves SHIFT:
    - Go to PARITY if the macro is defined.
    - Otherwise, if rem>1: decrement rem and either go to GAP (GAP_CYCLES>0; out=0, out_valid=0) or reload the pattern and present the MSB immediately (GAP_CYCLES=0).
    - Otherwise, if rem==1: go to IDLE with out_valid=0, out=0, busy=0, ready=1, done=1 for exactly one cycle.
- GAP
  - Holds out=0, out_valid=0 for exactly GAP_CYCLES cycles.
  - Then reloads the pattern and presents the MSB at the edge that exits GAP.
  - There is no gap after the final repeat.
- Stream length:
  - Total valid cycles = repeat_cnt × (PATTERN_W [+1 with parity]).
  - Total cycles from accept edge to done edge = valid cycles + (repeat_cnt−1) × GAP_CYCLES.
- done / start overlap: during the done cycle ready=1, so a start in that cycle is accepted and the next stream begins back-to-back.
- Ignored start: start while ready=0 is ignored, with no queuing. pattern and repeat_cnt changes mid-transfer have no effect.
- abort=1 at any edge while busy:
  - Next state is IDLE, out=0, out_valid=0, busy=0, ready=1.
  - No done pulse.
  - A partial pattern is acceptable.
- abort in IDLE: abort=1 together with start in IDLE means abort wins and the start is dropped.
- Counter widths: rem is CNT_W bits; bit_idx is clog2(PATTERN_W) bits. Counters cannot wrap because rem is loaded only from a nonzero value and only decremented while >1.

Optional Feature:
- Macro: SEQ_GEN_PARITY_EN
- Defined:
  - After the LSB of each repeat, a PARITY state presents one extra bit with out_valid=1.
  - The bit value is the XOR of all latched pattern bits (even parity).
  - After the parity bit, transitions continue as for the end of SHIFT: GAP, next repeat, or done.
- Undefined: the PARITY state and its logic are absent, and each repeat is exactly PATTERN_W bits.

Test Plan:
- Reset: rst held 3 cycles mid-transfer → out=0, out_valid=0, busy=0, ready=1, done=0 on the next cycle; no done pulse afterward.
- Basic: pattern=4'b1101, repeat_cnt=1, GAP=0 → out = 1,1,0,1 on 4 consecutive valid cycles, then done=1 for one cycle with ready=1.
- Repeats with gap: pattern=4'b1101, repeat_cnt=3, GAP_CYCLES=2 → 1101, 2 idle cycles, 1101, 2 idle cycles, 1101, then done. Exactly 16 cycles from accept edge to done edge.
- Zero count and back-to-back:
  - repeat_cnt=0 → no out_valid, done on the next cycle.
  - start asserted during the done cycle with pattern=4'b0110 → 0110 begins with no idle cycle.
- Abort and busy handling:
  - abort during bit 2 of repeat 2 → out_valid low on the next cycle, no done.
  - start while busy is ignored.
  - start and abort together in IDLE → nothing sent.
- SEQ_GEN_PARITY_EN defined, pattern=4'b1101, repeat_cnt=2 → stream 1101 1 1101 1 (parity=1), 10 valid cycles, then done.
